pipe_ripple_adder: RTL and testbench



---
 rtl/pipe_ripple_adder.sv | 159 +++++++++++++++
 tb/tb_pipe_ripple_adder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ripple_adder.sv
// pipe_ripple_adder
//   Pipelined ripple-carry adder. WIDTH-bit operands are cut into SEG_W-bit
//   segments; stage k adds segment k using the carry registered by stage k-1,
//   so the critical path covers only SEG_W bits. Latency is STAGES=WIDTH/SEG_W
//   advancing edges, throughput is one result per cycle. The whole pipe
//   advances together whenever the output is empty or being taken.
//
//   Optional build macro PIPE_RIPPLE_ADDER_SUB_EN adds port in_sub:
//   in_sub=1 computes in_a - in_b (in_a + ~in_b + 1, in_cin ignored) and
//   out_cout=1 then means "no borrow".
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   operand transaction present
//   in_ready   transaction accepted this cycle (= !out_valid || out_ready)
//   in_a/in_b  operands, WIDTH bits
//   in_cin     carry into bit 0
//   in_sub     subtract select (only with PIPE_RIPPLE_ADDER_SUB_EN)
//   out_valid  result present
//   out_ready  downstream takes the result
//   out_sum    sum, WIDTH bits
//   out_cout   carry out of bit WIDTH-1
//   out_ovf    signed overflow (carry into MSB xor carry out of MSB)

module pipe_ripple_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SEG_W;

    if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_check
        $error("pipe_ripple_adder: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
               WIDTH, SEG_W);
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is folded in at the pipe entry: B is inverted and the
    // carry forced to 1, so later stages only ever see an addition.
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic                     v_in;
        logic                     c_in;
        logic [SEG_W-1:0]         a_seg;
        logic [SEG_W-1:0]         b_seg;
        logic [SEG_W:0]           seg_add;
        logic [(k+1)*SEG_W-1:0]   s_nx;
        logic                     v_q;
        logic                     c_q;
        logic [(k+1)*SEG_W-1:0]   s_q;

        if (k == 0) begin : g_head
            assign v_in  = in_valid;
            assign c_in  = cin_eff;
            assign a_seg = in_a[SEG_W-1:0];
            assign b_seg = b_eff[SEG_W-1:0];
            assign s_nx  = seg_add[SEG_W-1:0];
        end else begin : g_body
            // The lowest still-unused segment of the forwarded operands
            // always sits at bit 0 of the previous stage's skew registers.
            assign v_in  = stg[k-1].v_q;
            assign c_in  = stg[k-1].c_q;
            assign a_seg = stg[k-1].g_fwd.a_q[SEG_W-1:0];
            assign b_seg = stg[k-1].g_fwd.b_q[SEG_W-1:0];
            assign s_nx  = {seg_add[SEG_W-1:0], stg[k-1].s_q};
        end

        assign seg_add = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= seg_add[SEG_W];
                s_q <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int REM_W = WIDTH - (k + 1) * SEG_W;

            logic [REM_W-1:0] a_nx;
            logic [REM_W-1:0] b_nx;
            logic [REM_W-1:0] a_q;
            logic [REM_W-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_nx = in_a[WIDTH-1:SEG_W];
                assign b_nx = b_eff[WIDTH-1:SEG_W];
            end else begin : g_src
                assign a_nx = stg[k-1].g_fwd.a_q[REM_W+SEG_W-1:SEG_W];
                assign b_nx = stg[k-1].g_fwd.b_q[REM_W+SEG_W-1:SEG_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB's own sum bit.
            logic msb_cin;
            logic ovf_q;

            assign msb_cin = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ seg_add[SEG_W-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= msb_cin ^ seg_add[SEG_W];
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign out_sum   = stg[STAGES-1].s_q;
    assign out_cout  = stg[STAGES-1].c_q;
    assign out_ovf   = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// tb_pipe_ripple_adder
//   Bench for pipe_ripple_adder at WIDTH=16, SEG_W=4 (four stages).
//   Expected results come from a plain-arithmetic reference model.

module tb_pipe_ripple_adder;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int ST = W / SW;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         cur_sub;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    logic         in_sub;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         acc;
        logic         dlv;
        logic         ovl;
        logic         rdy;
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
    } smp_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
    } res_t;

    res_t exp_q[$];

    pipe_ripple_adder #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   r;
        res_t         x;
        bb = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        x.sum = r[W-1:0];
        x.co  = r[W];
        x.ov  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return x;
    endfunction

    task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub, logic v);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        cur_sub  = sub;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        in_sub   = sub;
`endif
        in_valid = v;
    endtask

    // Samples at the falling edge, then steps past the next rising edge.
    task automatic tick(output smp_t s);
        @(negedge clk);
        s.acc = in_valid && in_ready;
        s.dlv = out_valid && out_ready;
        s.ovl = out_valid;
        s.rdy = in_ready;
        s.sum = out_sum;
        s.co  = out_cout;
        s.ov  = out_ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub,
                            output logic acc, output int lat, output smp_t r);
        smp_t s;
        drive(a, b, cin, sub, 1'b1);
        tick(s);
        acc = s.acc;
        in_valid = 1'b0;
        lat = -1;
        r = '0;
        for (int e = 1; e <= 20; e++) begin
            tick(s);
            if (s.ovl) begin
                lat = e;
                r = s;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] av [6];
        logic [W-1:0] bv [6];
        logic         cv [6];
        logic         acc;
        int           lat;
        smp_t         r;
        res_t         e;
        av[0] = 16'h1234; bv[0] = 16'h1111; cv[0] = 1'b0;
        av[1] = 16'hFFFF; bv[1] = 16'h0000; cv[1] = 1'b1;
        av[2] = 16'h7FFF; bv[2] = 16'h0001; cv[2] = 1'b0;
        for (int i = 3; i < 6; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
            cv[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = model(av[i], bv[i], cv[i], 1'b0);
            send_one(av[i], bv[i], cv[i], 1'b0, acc, lat, r);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept[%0d] got %b want 1", i, acc); end
            checks++; if (lat != ST) begin errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, ST); end
            checks++;
            if ({r.sum, r.co, r.ov} !== {e.sum, e.co, e.ov}) begin
                errors++;
                $display("FAIL basic_result[%0d] a=%h b=%h cin=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, av[i], bv[i], cv[i], r.sum, r.co, r.ov, e.sum, e.co, e.ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        smp_t s;
        logic exp_v;
        out_ready = 1'b1;
        for (int t = 0; t < 8 + ST + 2; t++) begin
            if (t < 8) drive(W'(t), W'(2 * t), 1'b0, 1'b0, 1'b1);
            else in_valid = 1'b0;
            tick(s);
            if (t < 8) begin
                checks++; if (s.rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[t=%0d] got %b want 1", t, s.rdy); end
            end
            exp_v = (t >= ST) && (t < ST + 8);
            checks++; if (s.ovl !== exp_v) begin errors++; $display("FAIL b2b_out_valid[t=%0d] got %b want %b", t, s.ovl, exp_v); end
            if (exp_v) begin
                checks++;
                if (s.sum !== W'(3 * (t - ST)) || s.co !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_sum[t=%0d] got %h/%b want %h/0", t, s.sum, s.co, W'(3 * (t - ST)));
                end
            end
        end
    endtask

    task automatic test_stall();
        smp_t s;
        res_t e;
        int   delivered;
        exp_q.delete();
        out_ready = 1'b0;
        for (int t = 0; t < ST; t++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
            tick(s);
            if (s.acc) exp_q.push_back(model(in_a, in_b, in_cin, cur_sub));
        end
        checks++; if (exp_q.size() != ST) begin errors++; $display("FAIL stall_fill got %0d accepted want %0d", exp_q.size(), ST); end
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
        for (int h = 0; h < 5; h++) begin
            tick(s);
            checks++; if (s.rdy !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", h, s.rdy); end
            if (exp_q.size() > 0) begin
                checks++;
                if ({s.ovl, s.sum, s.co, s.ov} !== {1'b1, exp_q[0].sum, exp_q[0].co, exp_q[0].ov}) begin
                    errors++;
                    $display("FAIL stall_hold[%0d] got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                             h, s.ovl, s.sum, s.co, s.ov, exp_q[0].sum, exp_q[0].co, exp_q[0].ov);
                end
            end
        end
        out_ready = 1'b1;
        delivered = 0;
        for (int t = 0; t < 20 && delivered < ST + 1; t++) begin
            tick(s);
            if (s.acc) begin
                exp_q.push_back(model(in_a, in_b, in_cin, cur_sub));
                in_valid = 1'b0;
            end
            if (s.dlv) begin
                delivered++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_release unexpected result sum=%h want none", s.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.sum, s.co, s.ov} !== {e.sum, e.co, e.ov}) begin
                        errors++;
                        $display("FAIL stall_release got %h/%b/%b want %h/%b/%b", s.sum, s.co, s.ov, e.sum, e.co, e.ov);
                    end
                end
            end
        end
        checks++; if (delivered != ST + 1) begin errors++; $display("FAIL stall_count got %0d want %0d", delivered, ST + 1); end
        for (int t = 0; t < 3; t++) begin
            tick(s);
            checks++; if (s.ovl !== 1'b0) begin errors++; $display("FAIL stall_dup[%0d] got out_valid %b want 0", t, s.ovl); end
        end
    endtask

    task automatic test_midreset();
        smp_t s;
        logic acc;
        int   lat;
        res_t e;
        out_ready = 1'b0;
        for (int t = 0; t < ST; t++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
            tick(s);
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_full got out_valid %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_drop got out_valid %b want 0", out_valid); end
        checks++; if ({out_sum, out_cout, out_ovf} !== '0) begin errors++; $display("FAIL midrst_clear got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 2 * ST; t++) begin
            tick(s);
            checks++; if (s.ovl !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] got out_valid %b want 0", t, s.ovl); end
        end
        e = model(16'hABCD, 16'h1357, 1'b1, 1'b0);
        send_one(16'hABCD, 16'h1357, 1'b1, 1'b0, acc, lat, s);
        checks++; if (lat != ST) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, ST); end
        checks++; if ({s.sum, s.co, s.ov} !== {e.sum, e.co, e.ov}) begin errors++; $display("FAIL midrst_result got %h/%b/%b want %h/%b/%b", s.sum, s.co, s.ov, e.sum, e.co, e.ov); end
    endtask

    task automatic test_random();
        smp_t s;
        res_t e;
        exp_q.delete();
        for (int n = 0; n < 400 + 2 * ST + 4; n++) begin
            if (n < 400) begin
                drive(W'($urandom), W'($urandom), 1'($urandom), SUB_ON ? 1'($urandom) : 1'b0,
                      $urandom_range(0, 9) < 7);
                out_ready = $urandom_range(0, 9) < 6;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            tick(s);
            checks++; if (s.rdy !== (!s.ovl || out_ready)) begin errors++; $display("FAIL rand_in_ready[%0d] got %b want %b", n, s.rdy, !s.ovl || out_ready); end
            if (s.acc) exp_q.push_back(model(in_a, in_b, in_cin, cur_sub));
            if (s.dlv) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_result[%0d] unexpected sum=%h want none", n, s.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.sum, s.co, s.ov} !== {e.sum, e.co, e.ov}) begin
                        errors++;
                        $display("FAIL rand_result[%0d] got %h/%b/%b want %h/%b/%b", n, s.sum, s.co, s.ov, e.sum, e.co, e.ov);
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
    endtask

`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    task automatic test_sub();
        smp_t s;
        logic acc;
        int   lat;
        out_ready = 1'b1;
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1, acc, lat, s);
        checks++; if (lat != ST) begin errors++; $display("FAIL sub_latency got %0d want %0d", lat, ST); end
        checks++; if ({s.sum, s.co} !== {16'hFFFE, 1'b0}) begin errors++; $display("FAIL sub_borrow got %h/%b want fffe/0", s.sum, s.co); end
        send_one(16'h8000, 16'h0001, 1'b1, 1'b1, acc, lat, s);
        checks++; if ({s.sum, s.co, s.ov} !== {16'h7FFF, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_ovf got %h/%b/%b want 7fff/1/1", s.sum, s.co, s.ov); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_midreset();
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
